// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state, request/response
// records and the address-range check.
package dmem_responder_pkg;

    typedef logic [31:0] u32;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        u32    addr;
        logic  we;
        strb_t strb;
        word_t wdata;
    } dmem_req_t;

    typedef struct packed {
        word_t rdata;
        logic  err;
    } dmem_resp_t;

    // Ordered checks keep the subtraction from ever wrapping below base.
    function automatic logic addr_err(input u32 addr, input u32 base, input u32 depth);
        if (addr[1:0] != 2'b00) return 1'b1;
        if (addr < base) return 1'b1;
        return ((addr - base) >> 2) >= depth;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered
// read port; contents are never reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    strb,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    word_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one outstanding request, fixed LATENCY wait cycles,
// then a held response until the initiator accepts it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter u32          BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_strb,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t   state;
    logic [3:0]    cnt;
    dmem_req_t     req_q;
    logic          err_q;
    logic          err_now;
    logic          commit_now;
    logic          commit_wait;
    logic          arr_en;
    logic          arr_we;
    logic [AW-1:0] arr_addr;
    strb_t         arr_strb;
    word_t         arr_wdata;
    word_t         arr_rdata;
    dmem_resp_t    resp;

    assign err_now = addr_err(req_addr, BASE_ADDR, u32'(DEPTH_WORDS));

    // The array access happens on the edge that enters RESP; with zero
    // latency that is the acceptance edge, so it is fed from the live inputs.
    always_comb begin
        commit_now  = reset && (state == IDLE) && req_valid && (LATENCY == 0);
        commit_wait = (state == WAIT) && (cnt <= 4'd1);
        if (commit_now) begin
            arr_en    = !err_now;
            arr_we    = req_we;
            arr_addr  = AW'((req_addr - BASE_ADDR) >> 2);
            arr_strb  = req_strb;
            arr_wdata = req_wdata;
        end else begin
            arr_en    = commit_wait && !err_q;
            arr_we    = req_q.we;
            arr_addr  = AW'((req_q.addr - BASE_ADDR) >> 2);
            arr_strb  = req_q.strb;
            arr_wdata = req_q.wdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .strb  (arr_strb),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            err_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{addr: req_addr, we: req_we, strb: req_strb, wdata: req_wdata};
                        err_q     <= err_now;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= err_now;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state      <= RESP;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        err_q      <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array read register holds its value until the next commit, so
    // gating it by state gives a stable load result that is 0 elsewhere.
    assign resp.rdata = (state == RESP && !err_q && !req_q.we) ? arr_rdata : '0;
    assign resp.err   = resp_err;
    assign resp_rdata = resp.rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 plus a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        sel;

    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic [31:0] resp_rdata_a;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    logic        m_req_ready, m_resp_valid, m_resp_err;
    logic [31:0] m_resp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid && !sel),
        .req_ready  (req_ready_a),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_strb   (req_strb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata_a),
        .resp_err   (resp_err_a)
    );

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (0),
        .BASE_ADDR   (32'h0000_0000)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid && sel),
        .req_ready  (req_ready_b),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_strb   (req_strb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    assign m_req_ready  = sel ? req_ready_b  : req_ready_a;
    assign m_resp_valid = sel ? resp_valid_b : resp_valid_a;
    assign m_resp_err   = sel ? resp_err_b   : resp_err_a;
    assign m_resp_rdata = sel ? resp_rdata_b : resp_rdata_a;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_resp_valid && lat < 40);
        chk("resp_valid_seen", m_resp_valid, 1);
    endtask

    task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
        @(negedge clk);
        chk("req_ready_idle", m_req_ready, 1);
        req_addr  = a;
        req_we    = w;
        req_strb  = s;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        rd = m_resp_rdata;
        er = m_resp_err;
        @(posedge clk);
        #1;
        chk("resp_valid_drop", m_resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{32'h0000_0000, 1'b1, 4'hF, 32'h0101_0101, 32'h0, 1'b0};
        vecs[1]  = '{32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[2]  = '{32'h0000_0010, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{32'h0000_0020, 1'b1, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
        vecs[4]  = '{32'h0000_0020, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0};
        vecs[5]  = '{32'h0000_0020, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h1122_AB44, 1'b0};
        vecs[6]  = '{32'h0000_0004, 1'b1, 4'hF, 32'h5566_7788, 32'h0, 1'b0};
        vecs[7]  = '{32'h0000_0030, 1'b1, 4'hF, 32'h0BAD_C0DE, 32'h0, 1'b0};
        vecs[8]  = '{32'h0000_0006, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{32'h0000_0006, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[10] = '{32'h0000_1000, 1'b1, 4'hF, 32'hAAAA_AAAA, 32'h0, 1'b1};
        vecs[11] = '{32'h0000_0004, 1'b0, 4'hF, 32'h0, 32'h5566_7788, 1'b0};
        vecs[12] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0, 32'h0101_0101, 1'b0};
        vecs[13] = '{32'h0000_0024, 1'b1, 4'hF, 32'h9988_7766, 32'h0, 1'b0};
        vecs[14] = '{32'h0000_0024, 1'b1, 4'h0, 32'h1234_5678, 32'h0, 1'b0};
        vecs[15] = '{32'h0000_0024, 1'b0, 4'h0, 32'h0, 32'h9988_7766, 1'b0};
        vecs[16] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_we     = 1'b0;
        req_strb   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        sel        = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", m_req_ready, 1);
            chk("rst_resp_valid", m_resp_valid, 0);
            chk("rst_resp_rdata", m_resp_rdata, 0);
            chk("rst_resp_err", m_resp_err, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", m_req_ready, 1);
        chk("rel_resp_valid", m_resp_valid, 0);
        chk("rel_resp_rdata", m_resp_rdata, 0);
        chk("rel_resp_err", m_resp_err, 0);

        for (int i = 0; i < 17; i++) begin
            xact(vecs[i].addr, vecs[i].we, vecs[i].strb, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Backpressure: response held for 5 cycles.
        resp_ready = 1'b0;
        @(negedge clk);
        req_addr  = 32'h10;
        req_we    = 1'b0;
        req_strb  = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        chk("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", m_resp_valid, 1);
            chk("bp_rdata_hold", m_resp_rdata, 32'hDEAD_BEEF);
            chk("bp_err_hold", m_resp_err, 0);
            chk("bp_req_ready_low", m_req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", m_resp_valid, 0);
        chk("bp_rdata_clear", m_resp_rdata, 0);
        chk("bp_req_ready_back", m_req_ready, 1);

        // Reset during WAIT of a store must abort it without touching storage.
        @(negedge clk);
        req_addr  = 32'h30;
        req_we    = 1'b1;
        req_strb  = 4'hF;
        req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", m_resp_valid, 0);
        chk("mid_rst_req_ready", m_req_ready, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_valid_hold", m_resp_valid, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", m_resp_valid, 0);
        end
        xact(32'h30, 1'b0, 4'hF, 32'h0, rd, er, lat);
        chk("post_rst_old_value", rd, 32'h0BAD_C0DE);
        chk("post_rst_err", 32'(er), 32'd0);

        // Zero-latency instance.
        sel = 1'b1;
        xact(32'h08, 1'b1, 4'hF, 32'h7777_0808, rd, er, lat);
        chk("lat0_store_latency", 32'(lat), 32'd1);
        chk("lat0_store_rdata", rd, 32'h0);
        xact(32'h08, 1'b0, 4'hF, 32'h0, rd, er, lat);
        chk("lat0_load_latency", 32'(lat), 32'd1);
        chk("lat0_load_rdata", rd, 32'h7777_0808);
        xact(32'h0A, 1'b0, 4'hF, 32'h0, rd, er, lat);
        chk("lat0_err", 32'(er), 32'd1);
        chk("lat0_err_rdata", rd, 32'h0);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
